beat_sequencer: RTL and testbench

- Step sequencer directly downstream of BPM_prescaler; consumes its slowCLK beat clock.
- Plays a 16-step note pattern, one step per slowCLK rising edge.
- Emits step index, note, one-cycle trigger and timed gate to the audio synthesis stage.
- Pattern is written by the control logic through a simple write port.

---
 rtl/beat_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_beat_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// beat_sequencer
//   16-step note sequencer driven by the slowCLK beat clock from BPM_prescaler.
//   slowCLK is treated as data: it is synchronised and edge-detected on CLK.
//   Each detected beat plays one pattern step. An enabled step raises TRIG for
//   one cycle, updates NOTE and (re)loads the gate counter.
//
// Optional feature macro: BEAT_SEQ_SWING_EN
//   When defined, an extra SWING input delays odd-numbered steps by SWING CLK
//   cycles after their beat. When undefined there is no SWING port and every
//   step plays on its own beat.
//
// Ports
//   CLK       system clock (only clock)
//   RST_N     asynchronous active-low reset
//   slowCLK   beat clock, sampled on CLK
//   PLAY      start request (level)
//   STOP      stop request (level, wins over PLAY)
//   WR_EN     pattern write strobe
//   WR_ADDR   step to write
//   WR_DATA   {enable, note}
//   GATE_LEN  gate high time in CLK cycles
//   SWING     (BEAT_SEQ_SWING_EN only) odd-step delay in CLK cycles
//   STEP      index of the step most recently played
//   NOTE      note of the last enabled step played
//   TRIG      one-cycle pulse when an enabled step plays
//   GATE      note gate level
//   RUNNING   high while ARMED or RUN
//   BAR_TICK  one-cycle pulse when STEP wraps to 0 in RUN
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; beats ignored, waiting for PLAY
// ARMED | started; next beat plays step 0
// RUN   | each beat advances to the next step (wrapping at STEPS-1)

module beat_sequencer #(
  parameter int STEPS  = 16,
  parameter int STEP_W = 4,
  parameter int NOTE_W = 8,
  parameter int GATE_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              slowCLK,
  input  logic              PLAY,
  input  logic              STOP,
  input  logic              WR_EN,
  input  logic [STEP_W-1:0] WR_ADDR,
  input  logic [NOTE_W:0]   WR_DATA,
  input  logic [GATE_W-1:0] GATE_LEN,
`ifdef BEAT_SEQ_SWING_EN
  input  logic [GATE_W-1:0] SWING,
`endif
  output logic [STEP_W-1:0] STEP,
  output logic [NOTE_W-1:0] NOTE,
  output logic              TRIG,
  output logic              GATE,
  output logic              RUNNING,
  output logic              BAR_TICK
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic                s0_q, s1_q;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                trig_q, trig_d;
  logic                gate_q, gate_d;
  logic                bar_q, bar_d;
  logic                run_q, run_d;
  logic [GATE_W-1:0]   gcnt_q, gcnt_d;
  logic [NOTE_W:0]     pat_q [STEPS];
  logic [NOTE_W:0]     pat_d [STEPS];

`ifdef BEAT_SEQ_SWING_EN
  logic                pend_q, pend_d;
  logic [STEP_W-1:0]   pidx_q, pidx_d;
  logic [GATE_W-1:0]   scnt_q, scnt_d;
  logic                defer_q, defer_d;
  logic                evt;
  logic                fire;
`endif

  logic                tick;
  logic                play;
  logic                play_wrap;
  logic [STEP_W-1:0]   play_idx;
  logic [STEP_W-1:0]   next_idx;
  logic [NOTE_W:0]     entry;

  always_comb begin
    tick      = s0_q & ~s1_q;
    next_idx  = step_q + STEP_W'(1);

    state_d   = state_q;
    step_d    = step_q;
    note_d    = note_q;
    trig_d    = 1'b0;
    bar_d     = 1'b0;
    gcnt_d    = (gcnt_q != '0) ? gcnt_q - GATE_W'(1) : gcnt_q;
    play      = 1'b0;
    play_wrap = 1'b0;
    play_idx  = '0;
    entry     = '0;

    // Play reads pat_q, so a write to the same step this cycle lands after the read.
    pat_d = pat_q;
    if (WR_EN) pat_d[WR_ADDR] = WR_DATA;

`ifdef BEAT_SEQ_SWING_EN
    pend_d  = pend_q;
    pidx_d  = pidx_q;
    scnt_d  = scnt_q;
    defer_d = 1'b0;
    evt     = tick | defer_q;
    // A pending step is flushed early if the next beat shows up; that beat is
    // then replayed one cycle later through defer_q.
    fire    = pend_q & ((scnt_q == GATE_W'(1)) | evt);

    case (state_q)
      ST_IDLE: begin
        if (PLAY) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (evt) begin
          play    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          play     = 1'b1;
          play_idx = pidx_q;
          pend_d   = 1'b0;
          defer_d  = evt;
        end else if (pend_q) begin
          scnt_d = scnt_q - GATE_W'(1);
        end else if (evt) begin
          if (next_idx[0] && (SWING != '0)) begin
            pend_d = 1'b1;
            pidx_d = next_idx;
            scnt_d = SWING;
          end else begin
            play      = 1'b1;
            play_idx  = next_idx;
            play_wrap = (step_q == STEP_W'(STEPS - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    case (state_q)
      ST_IDLE: begin
        if (PLAY) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (tick) begin
          play    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          play      = 1'b1;
          play_idx  = next_idx;
          play_wrap = (step_q == STEP_W'(STEPS - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif

    if (play) begin
      entry  = pat_q[play_idx];
      step_d = play_idx;
      bar_d  = play_wrap;
      if (entry[NOTE_W]) begin
        trig_d = 1'b1;
        note_d = entry[NOTE_W-1:0];
        gcnt_d = GATE_LEN;
      end
    end

    if (STOP) begin
      state_d = ST_IDLE;
      step_d  = '0;
      note_d  = note_q;
      gcnt_d  = '0;
      trig_d  = 1'b0;
      bar_d   = 1'b0;
`ifdef BEAT_SEQ_SWING_EN
      pend_d  = 1'b0;
      defer_d = 1'b0;
`endif
    end

    gate_d = (gcnt_d != '0);
    run_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      step_q  <= '0;
      note_q  <= '0;
      trig_q  <= 1'b0;
      gate_q  <= 1'b0;
      bar_q   <= 1'b0;
      run_q   <= 1'b0;
      gcnt_q  <= '0;
      pat_q   <= '{default: '0};
`ifdef BEAT_SEQ_SWING_EN
      pend_q  <= 1'b0;
      pidx_q  <= '0;
      scnt_q  <= '0;
      defer_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s0_q    <= slowCLK;
      s1_q    <= s0_q;
      step_q  <= step_d;
      note_q  <= note_d;
      trig_q  <= trig_d;
      gate_q  <= gate_d;
      bar_q   <= bar_d;
      run_q   <= run_d;
      gcnt_q  <= gcnt_d;
      pat_q   <= pat_d;
`ifdef BEAT_SEQ_SWING_EN
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      scnt_q  <= scnt_d;
      defer_q <= defer_d;
`endif
    end
  end

  assign STEP     = step_q;
  assign NOTE     = note_q;
  assign TRIG     = trig_q;
  assign GATE     = gate_q;
  assign RUNNING  = run_q;
  assign BAR_TICK = bar_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer. The stimulus side keeps an abstract
// model (mode, position, pattern array) and pushes the expected play events
// and run/stop changes with their due cycle; the monitor pops and compares
// on every falling edge.

module tb_beat_sequencer;
  localparam int STEPS = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        slowCLK = 1'b0;
  logic        PLAY = 1'b0;
  logic        STOP = 1'b0;
  logic        WR_EN = 1'b0;
  logic [3:0]  WR_ADDR = '0;
  logic [8:0]  WR_DATA = '0;
  logic [15:0] GATE_LEN = '0;
`ifdef BEAT_SEQ_SWING_EN
  logic [15:0] SWING = '0;
`endif
  logic [3:0]  STEP;
  logic [7:0]  NOTE;
  logic        TRIG, GATE, RUNNING, BAR_TICK;

  beat_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .slowCLK(slowCLK), .PLAY(PLAY), .STOP(STOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .GATE_LEN(GATE_LEN),
`ifdef BEAT_SEQ_SWING_EN
    .SWING(SWING),
`endif
    .STEP(STEP), .NOTE(NOTE), .TRIG(TRIG), .GATE(GATE),
    .RUNNING(RUNNING), .BAR_TICK(BAR_TICK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {int cyc; int step; int note; bit trig; bit bar; int len;} out_ev_t;
  typedef struct {int cyc; bit stop;} ctl_ev_t;
  out_ev_t out_q[$];
  ctl_ev_t ctl_q[$];

  // reference model (stimulus side)
  int         mode = 0;   // 0 stopped, 1 waiting for first beat, 2 stepping
  int         pos = 0;
  logic [8:0] pat [STEPS];
  bit         d1 = 0, d2 = 0;
  int         cur_glen = 0;

  // monitor-side expectations
  bit mon_en = 0;
  bit exp_run = 0;
  int exp_step = 0;
  int exp_note = 0;
  int gate_until = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    out_ev_t e;
    bit et, eb;
    if (mon_en) begin
      while (ctl_q.size() > 0 && ctl_q[0].cyc <= cyc) begin
        if (ctl_q[0].stop) begin
          exp_run  = 0;
          exp_step = 0;
          if (gate_until > cyc) gate_until = cyc;
        end else begin
          exp_run = 1;
        end
        void'(ctl_q.pop_front());
      end
      et = 0;
      eb = 0;
      if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
        e = out_q.pop_front();
        chk("event_time", cyc, e.cyc);
        et = e.trig;
        eb = e.bar;
        exp_step = e.step;
        if (e.trig) begin
          exp_note   = e.note;
          gate_until = cyc + e.len;
        end
      end
      chk("TRIG", int'(TRIG), int'(et));
      chk("BAR_TICK", int'(BAR_TICK), int'(eb));
      chk("STEP", int'(STEP), exp_step);
      chk("NOTE", int'(NOTE), exp_note);
      chk("GATE", int'(GATE), int'(cyc < gate_until));
      chk("RUNNING", int'(RUNNING), int'(exp_run));
    end
  end

  // Drive one cycle of inputs and advance the model to the edge that samples them.
  task automatic drv(input bit slow, input bit play, input bit stop,
                     input bit wr, input int addr, input int data);
    bit      tick;
    out_ev_t e;
    ctl_ev_t c;
    @(posedge CLK);
    #1;
    slowCLK  = slow;
    PLAY     = play;
    STOP     = stop;
    WR_EN    = wr;
    WR_ADDR  = addr[3:0];
    WR_DATA  = data[8:0];
    GATE_LEN = cur_glen[15:0];
    tick = d1 && !d2;
    d2 = d1;
    d1 = slow;
    if (stop) begin
      c.cyc = cyc + 1;
      c.stop = 1;
      ctl_q.push_back(c);
      mode = 0;
    end else begin
      if (tick && mode != 0) begin
        if (mode == 1) begin
          pos   = 0;
          e.bar = 0;
          mode  = 2;
        end else begin
          e.bar = (pos == STEPS - 1);
          pos   = (pos + 1) % STEPS;
        end
        e.cyc  = cyc + 1;
        e.step = pos;
        e.trig = pat[pos][8];
        e.note = int'(pat[pos][7:0]);
        e.len  = cur_glen;
        out_q.push_back(e);
      end
      if (play && mode == 0) begin
        c.cyc = cyc + 1;
        c.stop = 0;
        ctl_q.push_back(c);
        mode = 1;
      end
    end
    if (wr) pat[addr[3:0]] = data[8:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input int per);
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    idle(per - 2);
  endtask

  initial begin
    int ph, per;
    bit sl;
    for (int i = 0; i < STEPS; i++) pat[i] = '0;

    // reset with random inputs
    repeat (4) begin
      @(posedge CLK);
      #1;
      slowCLK  = 1'($urandom);
      PLAY     = 1'($urandom);
      STOP     = 1'($urandom);
      WR_EN    = 1'($urandom);
      WR_ADDR  = 4'($urandom);
      WR_DATA  = 9'($urandom);
      GATE_LEN = 16'($urandom);
    end
    @(negedge CLK);
    chk("rst_STEP", int'(STEP), 0);
    chk("rst_NOTE", int'(NOTE), 0);
    chk("rst_TRIG", int'(TRIG), 0);
    chk("rst_GATE", int'(GATE), 0);
    chk("rst_RUNNING", int'(RUNNING), 0);
    chk("rst_BAR_TICK", int'(BAR_TICK), 0);
    slowCLK = 0; PLAY = 0; STOP = 0; WR_EN = 0; WR_ADDR = '0; WR_DATA = '0; GATE_LEN = '0;
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1;

    // basic pattern: enabled, disabled, enabled
    cur_glen = 5;
    drv(0, 0, 0, 1, 0, 9'h13C);
    drv(0, 0, 0, 1, 1, 9'h040);
    drv(0, 0, 0, 1, 2, 9'h143);
    drv(0, 1, 0, 0, 0, 0);
    idle(2);
    repeat (3) beat(12);

    // STOP in the tick cycle while the gate is high, then PLAY+STOP together
    cur_glen = 30;
    drv(0, 0, 0, 1, 3, 9'h150);
    drv(0, 0, 0, 1, 4, 9'h155);
    beat(12);
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 0, 0, 0);
    idle(4);
    drv(0, 1, 1, 0, 0, 0);
    idle(2);
    repeat (2) beat(10);

    // long gate: legato across all steps
    for (int i = 0; i < STEPS; i++) drv(0, 0, 0, 1, i, 256 + int'($urandom_range(0, 255)));
    cur_glen = 1000;
    drv(0, 1, 0, 0, 0, 0);
    idle(2);
    repeat (6) beat(200);
    drv(0, 0, 1, 0, 0, 0);
    idle(3);

    // full bar and wrap with a mixed random pattern
    for (int i = 0; i < STEPS; i++) drv(0, 0, 0, 1, i, int'($urandom_range(0, 511)));
    cur_glen = 3;
    drv(0, 1, 0, 0, 0, 0);
    idle(2);
    repeat (18) beat(8);

    // random soak
    ph = 0;
    per = 6;
    for (int k = 0; k < 3000; k++) begin
      if (ph >= per) begin
        ph = 0;
        per = int'($urandom_range(4, 24));
      end
      sl = (ph < 2);
      ph++;
      if ($urandom_range(0, 19) == 0) cur_glen = int'($urandom_range(0, 40));
      drv(sl, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
          int'($urandom_range(0, 511)));
    end

    drv(0, 0, 1, 0, 0, 0);
    idle(4);
    for (int k = 0; k < 20 && (out_q.size() > 0 || ctl_q.size() > 0); k++) idle(1);
    @(negedge CLK);
    chk("out_q_drained", out_q.size(), 0);
    chk("ctl_q_drained", ctl_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
